// File: rtl/mont_result_streamer_pkg.sv
// mont_result_streamer_pkg: state encoding, sizing defaults and result-entry layout
package mont_result_streamer_pkg;

    localparam int MRS_RADIX     = 32;
    localparam int MRS_WIDTH     = 14;
    localparam int MRS_WIDTH_LOG = $clog2(MRS_WIDTH);

    typedef enum logic [1:0] {IDLE, RD0, RD1, DRAIN} state_e;

    // A buffered word is {sel, last, data}; these are the bit positions above data
    localparam int ENTRY_SEL_OFS  = 1;
    localparam int ENTRY_LAST_OFS = 0;

endpackage

// File: rtl/mont_result_streamer_fifo.sv
// res_skid_fifo: two-entry output buffer with a registered head entry
module res_skid_fifo #(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d, after_pop;

    assign after_pop = cnt_q - {1'b0, pop_i};
    assign head_o    = e0_q;
    assign count_o   = cnt_q;

    // Shift on pop, then write the incoming word into the first free slot
    always_comb begin
        e0_d  = pop_i ? e1_q : e0_q;
        e1_d  = pop_i ? '0 : e1_q;
        cnt_d = after_pop + {1'b0, push_i};
        if (push_i && after_pop == 2'd0) e0_d = din_i;
        if (push_i && after_pop == 2'd1) e1_d = din_i;
    end

    // Entry and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mont_result_streamer.sv
// mont_result_streamer: drains both Montgomery result memories onto a valid/ready stream
module mont_result_streamer
    import mont_result_streamer_pkg::*;
#(
    parameter int RADIX = MRS_RADIX,
    parameter int WIDTH = MRS_WIDTH,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mult_0_mem_res_rd_en,
    output logic [WIDTH_LOG-1:0] mult_0_mem_res_rd_addr,
    input  logic [RADIX-1:0]     mult_0_mem_res_dout,
    output logic                 mult_1_mem_res_rd_en,
    output logic [WIDTH_LOG-1:0] mult_1_mem_res_rd_addr,
    input  logic [RADIX-1:0]     mult_1_mem_res_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RADIX-1:0]     m_data,
    output logic                 m_sel,
    output logic                 m_last
);

    state_e               state_q, state_d;
    logic [WIDTH_LOG-1:0] addr_q, addr_d, addr0_q, addr1_q;
    logic                 infl_q, infl_sel_q, infl_last_q, done_q, done_d;
    logic [1:0]           fifo_cnt;
    logic [2:0]           occ;
    logic                 pop, issue, at_end;
    logic [RADIX+1:0]     head, push_entry;

    assign pop        = m_valid && m_ready;
    assign occ        = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, pop};
    assign issue      = (state_q == RD0 || state_q == RD1) && occ < 3'd2;
    assign at_end     = addr_q == WIDTH_LOG'(WIDTH - 1);
    assign push_entry = {infl_sel_q, infl_last_q, infl_sel_q ? mult_1_mem_res_dout : mult_0_mem_res_dout};

    assign mult_0_mem_res_rd_en   = issue && state_q == RD0;
    assign mult_1_mem_res_rd_en   = issue && state_q == RD1;
    assign mult_0_mem_res_rd_addr = mult_0_mem_res_rd_en ? addr_q : addr0_q;
    assign mult_1_mem_res_rd_addr = mult_1_mem_res_rd_en ? addr_q : addr1_q;

    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign m_valid = fifo_cnt != 2'd0;
    assign m_data  = head[RADIX-1:0];
    assign m_sel   = head[RADIX + ENTRY_SEL_OFS];
    assign m_last  = head[RADIX + ENTRY_LAST_OFS];

    // Sequencer: walk memory 0 then memory 1, then wait for the buffer to empty
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD0;
                    addr_d  = '0;
                end
            end
            RD0, RD1: begin
                if (issue) begin
                    addr_d = at_end ? '0 : addr_q + WIDTH_LOG'(1);
                    if (at_end) state_d = (state_q == RD0) ? RD1 : DRAIN;
                end
            end
            DRAIN: begin
                if (!infl_q && fifo_cnt == {1'b0, pop}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            infl_q      <= 1'b0;
            infl_sel_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr0_q     <= mult_0_mem_res_rd_addr;
            addr1_q     <= mult_1_mem_res_rd_addr;
            infl_q      <= issue;
            infl_sel_q  <= issue ? state_q == RD1 : infl_sel_q;
            infl_last_q <= issue ? at_end : infl_last_q;
            done_q      <= done_d;
        end
    end

    res_skid_fifo #(.DW(RADIX + 2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (infl_q),
        .pop_i   (pop),
        .din_i   (push_entry),
        .head_o  (head),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_mont_result_streamer.sv
// tb_mont_result_streamer: directed checks of ordering, backpressure, timing and reset
module tb_mont_result_streamer;

    localparam int RADIX = 32;
    localparam int WIDTH = 14;
    localparam int WL    = $clog2(WIDTH);
    localparam int NW    = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             m_ready = 1'b0;
    logic             busy, done, rd_en0, rd_en1, m_valid, m_sel, m_last;
    logic [WL-1:0]    rd_addr0, rd_addr1;
    logic [RADIX-1:0] dout0 = '0, dout1 = '0, m_data;

    int checks = 0, errors = 0;
    int issued = 0, accepted = 0, done_cnt = 0, done_edge = 0, cyc = 0, e0 = 0;
    bit mon_en = 1'b0;

    mont_result_streamer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .mult_0_mem_res_rd_en   (rd_en0),
        .mult_0_mem_res_rd_addr (rd_addr0),
        .mult_0_mem_res_dout    (dout0),
        .mult_1_mem_res_rd_en   (rd_en1),
        .mult_1_mem_res_rd_addr (rd_addr1),
        .mult_1_mem_res_dout    (dout1),
        .m_valid                (m_valid),
        .m_ready                (m_ready),
        .m_data                 (m_data),
        .m_sel                  (m_sel),
        .m_last                 (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en0) dout0 <= 32'h1000_0000 + 32'(rd_addr0);
        if (rd_en1) dout1 <= 32'h2000_0000 + 32'(rd_addr1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        logic pop, sel;
        int k;
        if (mon_en) begin
            pop = m_valid && m_ready;
            if (issued >= WIDTH) check("rd0_quiet", rd_en0, 0);
            if (issued >= NW) check("no_extra_rd", rd_en1, 0);
            if (rd_en0 || rd_en1) begin
                check("rd_budget", (issued - accepted - int'(pop)) < 2, 1);
                check("rd_sel", {rd_en1, rd_en0}, issued >= WIDTH ? 2'b10 : 2'b01);
                check("rd_addr", rd_en1 ? rd_addr1 : rd_addr0, issued % WIDTH);
                issued++;
            end
            if (pop) begin
                k   = accepted % WIDTH;
                sel = accepted >= WIDTH;
                check("no_overrun", accepted < NW, 1);
                check("m_data", m_data, (sel ? 32'h2000_0000 : 32'h1000_0000) + 32'(k));
                check("m_sel", m_sel, sel);
                check("m_last", m_last, k == WIDTH - 1);
                accepted++;
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
                check("done_after_all", accepted, NW);
            end
        end
    end

    task automatic clear_mon();
        issued   = 0;
        accepted = 0;
        done_cnt = 0;
    endtask

    task automatic run_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input bit toggle);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(posedge clk);
            #1 if (toggle) m_ready = ~m_ready;
        end
        check("done_seen", done_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("word_count", accepted, NW);
        check("busy_end", busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {busy, done, rd_en0, rd_en1, m_valid, m_sel, m_last}, 0);
        check({tag, "_addr"}, {rd_addr0, rd_addr1}, 0);
        check({tag, "_data"}, m_data, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // full drain at one word per cycle, with latency and done timing
        m_ready = 1'b1;
        run_start();
        check("first_rd", {rd_en0, rd_addr0}, {1'b1, 4'd0});
        check("busy_start", busy, 1);
        @(posedge clk);
        #1 check("valid_e1", m_valid, 0);
        @(posedge clk);
        #1 check("valid_e2", {m_valid, m_data}, {1'b1, 32'h1000_0000});
        wait_done(1'b0);
        check("done_edge", done_edge - e0, 30);

        // sink stalled for 10 cycles: head held, only two reads issued
        clear_mon();
        m_ready = 1'b0;
        run_start();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (i >= 1) check("stall_head", {m_valid, m_sel, m_data}, {2'b10, 32'h1000_0000});
        end
        check("stall_issued", issued, 2);
        m_ready = 1'b1;
        wait_done(1'b0);

        // alternating ready
        clear_mon();
        m_ready = 1'b1;
        run_start();
        wait_done(1'b1);

        // second start while busy is ignored
        clear_mon();
        m_ready = 1'b1;
        run_start();
        repeat (3) @(posedge clk);
        #1 check("busy_mid", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0);

        // reset after five words, then a clean restart
        clear_mon();
        m_ready = 1'b1;
        run_start();
        for (int i = 0; i < 100 && accepted < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("reached_five", accepted, 5);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1 check_quiet("async_rst");
        repeat (2) @(posedge clk);
        #1 check("no_done_in_rst", {done, 1'(done_cnt != 0)}, 0);
        rst_n = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        run_start();
        check("restart_rd", {rd_en0, rd_addr0}, {1'b1, 4'd0});
        wait_done(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mont_result_streamer.md
Name: mont_result_streamer

Overview:
Reader-side companion to Montgomery_multiplier. It drains the two result memories (mult_0 res, then mult_1 res) word by word through their synchronous read ports. Words leave on a valid/ready stream towards the host/SW interface. Replaces the software-style result readback with a backpressure-safe hardware engine; start is normally tied to the multiplier's done.

Parameters:
RADIX, 32, bits per result word (m_data width)
WIDTH, 14, words per result; addresses 0..WIDTH-1
WIDTH_LOG, clog2(WIDTH), localparam, address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin draining both results
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final word handshake
mult_0_mem_res_rd_en  out  1  read enable, result memory 0
mult_0_mem_res_rd_addr  out  WIDTH_LOG  read address, result memory 0
mult_0_mem_res_dout  in  RADIX  read data, valid one cycle after rd_en
mult_1_mem_res_rd_en  out  1  read enable, result memory 1
mult_1_mem_res_rd_addr  out  WIDTH_LOG  read address, result memory 1
mult_1_mem_res_dout  in  RADIX  read data, valid one cycle after rd_en
m_valid  out  1  stream word valid
m_ready  in  1  stream sink ready
m_data  out  RADIX  result word
m_sel  out  1  0 = word from mult_0, 1 = from mult_1
m_last  out  1  high on word WIDTH-1 of each result

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; both FIFO entries and the in-flight flag cleared; all outputs 0 (busy, done, rd_en, rd_addr, m_valid, m_data, m_sel, m_last).
- Memory timing: rd_en/rd_addr driven in cycle N; dout sampled at the edge ending cycle N+1. Exactly one read is in flight at a time. The FIFO entry carries {sel, last, data}.
- Output buffer: 2-entry FIFO (res_skid_fifo).
  - m_valid = FIFO non-empty; m_data, m_sel and m_last come from the head entry.
  - Pop occurs when m_valid && m_ready.
  - The head entry stays stable while m_valid && !m_ready.
- Issue rule: a read is issued in a cycle iff the FSM is RD0/RD1 and (fifo_count + inflight - pop) < 2. This sustains 1 word/cycle with m_ready held high and never overflows.
- rd_en is high only in issue cycles. The non-selected memory's rd_en is 0. rd_addr holds its last value when not issuing.
- FSM states:
  - IDLE: start=1 → RD0, addr=0, busy=1. start is ignored in all other states.
  - RD0: on each issue, addr++. Issue at addr WIDTH-1 → RD1, addr=0 (wrap).
  - RD1: same sequence on memory 1. Issue at addr WIDTH-1 → DRAIN.
  - DRAIN: waits for FIFO empty and inflight=0, then → IDLE with done=1 for one cycle and busy=0 in the same cycle.
- m_last=1 for word WIDTH-1 of each result; m_sel tells the two apart. done fires only after the mult_1 last word.
- Timing with m_ready constantly 1 (start sampled at edge E0):
  - first read issued in cycle E0→E1;
  - m_valid first high after E2;
  - 2*WIDTH handshakes at edges E3..E(2*WIDTH+2);
  - done high for the cycle following edge E(2*WIDTH+2).
- Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- Reset mid-operation aborts immediately: FIFO flushed, no done pulse. A later start restarts from mult_0 addr 0.

Decomposition:
- Shared package: FSM state encoding (IDLE, RD0, RD1, DRAIN); FIFO entry packing {sel, last, data[RADIX-1:0]}; WIDTH_LOG derivation via the common clog2 macro.
- Sub-module res_skid_fifo:
  - 2-entry, RADIX+2 bits wide;
  - push/pop/count ports, same clk/rst_n;
  - registered head output.

Test Plan:
- Memories preloaded with mult_0[i]=0x1000_0000+i, mult_1[i]=0x2000_0000+i; start pulse, m_ready=1 → 28 words in order 0x1000_0000..0x1000_000D (sel 0) then 0x2000_0000..0x2000_000D (sel 1); m_last on 0x1000_000D and 0x2000_000D; done exactly 30 edges after the start edge.
- Same preload; m_ready=0 for 10 cycles after start → m_valid=1 with m_data=0x1000_0000 held stable; rd_en stops after 2 words buffered; release → no loss, no duplication, order intact.
- m_ready toggling 1,0,1,0 → all 28 words delivered in order; rd_en never issues when FIFO+inflight=2; done once, after 0x2000_000D accepted.
- Second start pulse asserted while busy (mid-RD0) → ignored; exactly 28 words and one done.
- rst_n pulled low after 5 words → all outputs 0 asynchronously, no done; new start → stream restarts at 0x1000_0000 with rd_addr=0.
- Address wrap check → mult_0 rd_addr sequence 0..13, then mult_1 rd_addr 0..13; mult_0 rd_en=0 throughout RD1.
